// File: rtl/trc_reg_responder.sv
// Wait-state register responder: 32-word register file plus CTRL/STATUS words
// for launching timed calibration operations and counting protocol errors.
module trc_reg_responder #(
   parameter int WAIT_CYCLES = 2,
   parameter int OP_CYCLES   = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  avl_address,
   input  logic [31:0] avl_writedata,
   input  logic        avl_read_req,
   input  logic        avl_write_req,
   output logic        avl_busy,
   output logic [31:0] avl_readdata,
   output logic        op_start,
   output logic        op_busy,
   output logic [7:0]  err_cnt
);

   localparam logic [3:0] WCNT_INIT   = 4'(WAIT_CYCLES);
   localparam logic [7:0] OP_INIT     = 8'(OP_CYCLES);
   localparam logic [7:0] ADDR_CTRL   = 8'h20;
   localparam logic [7:0] ADDR_STATUS = 8'h21;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

   state_t      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic        dual_q, dual_d;
   logic        busy_q;
   logic [31:0] rdata_q, rdata_d;
   logic        op_start_q, op_start_d;
   logic        op_busy_q, op_busy_d;
   logic [7:0]  op_cnt_q, op_cnt_d;
   logic [7:0]  err_q, err_d;
   logic [1:0]  err_inc;
   logic [8:0]  err_sum;
   logic [31:0] rf_we;
   logic [31:0] rf_q [32];
   logic        commit;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      dual_d  = dual_q;
      case (state_q)
         ST_IDLE: begin
            if (avl_read_req || avl_write_req) begin
               addr_d  = avl_address;
               wdata_d = avl_writedata;
               wr_d    = avl_write_req;
               dual_d  = avl_read_req && avl_write_req;
               wcnt_d  = WCNT_INIT;
               state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
            end
         end
         ST_WAIT: begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q <= 4'd1) state_d = ST_ACK;
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The *_d capture fields hold the access being completed on the ACK-entry
   // edge, whether it was captured earlier or is being captured right now.
   assign commit = (state_d == ST_ACK) && (state_q != ST_ACK);

   always_comb begin
      rf_we      = '0;
      rdata_d    = rdata_q;
      err_inc    = 2'd0;
      op_start_d = 1'b0;
      op_busy_d  = op_busy_q;
      op_cnt_d   = op_cnt_q;
      if (op_busy_q) begin
         op_cnt_d = op_cnt_q - 8'd1;
         if (op_cnt_q <= 8'd1) begin
            op_busy_d = 1'b0;
            op_cnt_d  = 8'd0;
         end
      end
      if (commit) begin
         if (dual_d) err_inc = err_inc + 2'd1;
         if (wr_d) begin
            if (addr_d < ADDR_CTRL) begin
               rf_we[addr_d[4:0]] = 1'b1;
            end else if (addr_d == ADDR_CTRL) begin
               if (wdata_d[0]) begin
                  if (op_busy_q) begin
                     err_inc = err_inc + 2'd1;
                  end else begin
                     op_start_d = 1'b1;
                     op_busy_d  = 1'b1;
                     op_cnt_d   = OP_INIT;
                  end
               end
            end else begin
               err_inc = err_inc + 2'd1;
            end
         end else begin
            if (addr_d < ADDR_CTRL) begin
               rdata_d = rf_q[addr_d[4:0]];
            end else if (addr_d == ADDR_CTRL) begin
               rdata_d = 32'h0;
            end else if (addr_d == ADDR_STATUS) begin
               rdata_d = {16'h0, err_q, 7'h0, op_busy_q};
            end else begin
               rdata_d = 32'h0;
               err_inc = err_inc + 2'd1;
            end
         end
      end
      err_sum = {1'b0, err_q} + {7'h0, err_inc};
      err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         wcnt_q     <= 4'd0;
         addr_q     <= 8'h0;
         wdata_q    <= 32'h0;
         wr_q       <= 1'b0;
         dual_q     <= 1'b0;
         busy_q     <= 1'b1;
         rdata_q    <= 32'h0;
         op_start_q <= 1'b0;
         op_busy_q  <= 1'b0;
         op_cnt_q   <= 8'd0;
         err_q      <= 8'd0;
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wr_q       <= wr_d;
         dual_q     <= dual_d;
         busy_q     <= (state_d != ST_ACK);
         rdata_q    <= rdata_d;
         op_start_q <= op_start_d;
         op_busy_q  <= op_busy_d;
         op_cnt_q   <= op_cnt_d;
         err_q      <= err_d;
         for (int i = 0; i < 32; i++) begin
            if (rf_we[i]) rf_q[i] <= wdata_d;
         end
      end
   end

   assign avl_busy     = busy_q;
   assign avl_readdata = rdata_q;
   assign op_start     = op_start_q;
   assign op_busy      = op_busy_q;
   assign err_cnt      = err_q;

endmodule

// File: tb/tb_trc_reg_responder.sv
// Directed bench: unit 0 uses WAIT_CYCLES=2/OP_CYCLES=8, unit 1 uses
// WAIT_CYCLES=0 for the zero-wait and back-to-back request cases.
module tb_trc_reg_responder;

   logic        clk;
   logic        reset_n;
   logic [7:0]  addr_s  [2];
   logic [31:0] wd_s    [2];
   logic [1:0]  rd_s;
   logic [1:0]  wr_s;
   logic [1:0]  busy_s;
   logic [31:0] rdata_s [2];
   logic [1:0]  ops;
   logic [1:0]  opb;
   logic [7:0]  errs    [2];

   int n_checks = 0;
   int n_errors = 0;
   int start_cnt = 0;
   int busy_cyc = 0;

   trc_reg_responder #(.WAIT_CYCLES(2), .OP_CYCLES(8)) dut0 (
      .clock(clk), .reset_n(reset_n),
      .avl_address(addr_s[0]), .avl_writedata(wd_s[0]),
      .avl_read_req(rd_s[0]), .avl_write_req(wr_s[0]),
      .avl_busy(busy_s[0]), .avl_readdata(rdata_s[0]),
      .op_start(ops[0]), .op_busy(opb[0]), .err_cnt(errs[0])
   );

   trc_reg_responder #(.WAIT_CYCLES(0), .OP_CYCLES(3)) dut1 (
      .clock(clk), .reset_n(reset_n),
      .avl_address(addr_s[1]), .avl_writedata(wd_s[1]),
      .avl_read_req(rd_s[1]), .avl_write_req(wr_s[1]),
      .avl_busy(busy_s[1]), .avl_readdata(rdata_s[1]),
      .op_start(ops[1]), .op_busy(opb[1]), .err_cnt(errs[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count op_start pulses and op_busy cycles of unit 0, one sample per cycle.
   always @(negedge clk) begin
      if (ops[0]) start_cnt++;
      if (opb[0]) busy_cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   // Called #1 after an edge with the unit idle; returns #1 after the edge
   // following ACK, with the unit idle again.
   task automatic access(input int u, input logic rd, input logic wr, input logic [7:0] a,
                         input logic [31:0] wd, output logic [31:0] rdo);
      int cyc;
      int lat_exp;
      lat_exp   = (u == 0) ? 3 : 1;
      addr_s[u] = a;
      wd_s[u]   = wd;
      rd_s[u]   = rd;
      wr_s[u]   = wr;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (busy_s[u] && cyc < 20);
      check($sformatf("ack_latency u%0d a%02h", u, a), 32'(cyc), 32'(lat_exp));
      rdo     = rdata_s[u];
      rd_s[u] = 1'b0;
      wr_s[u] = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("ack_one_cycle u%0d", u), 32'(busy_s[u]), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int base_s;
      int base_b;
      bit done;

      reset_n = 1'b0;
      rd_s = '0;
      wr_s = '0;
      for (int i = 0; i < 2; i++) begin
         addr_s[i] = 8'h0;
         wd_s[i]   = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy_s[0]), 32'd1);
      check("rst_rdata", rdata_s[0], 32'h0);
      check("rst_op_start", 32'(ops[0]), 32'd0);
      check("rst_op_busy", 32'(opb[0]), 32'd0);
      check("rst_err", 32'(errs[0]), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      access(0, 1'b0, 1'b1, 8'h05, 32'hDEADBEEF, rd);
      access(0, 1'b1, 1'b0, 8'h05, 32'h0, rd);
      check("rd_05", rd, 32'hDEADBEEF);
      access(0, 1'b0, 1'b1, 8'h1F, 32'hCAFEF00D, rd);
      access(0, 1'b1, 1'b0, 8'h1F, 32'h0, rd);
      check("rd_1f", rd, 32'hCAFEF00D);
      access(0, 1'b1, 1'b0, 8'h00, 32'h0, rd);
      check("rd_00_reset", rd, 32'h0);

      access(0, 1'b1, 1'b0, 8'h40, 32'h0, rd);
      check("rd_unmapped", rd, 32'h0);
      check("err_unmapped", 32'(errs[0]), 32'd1);
      access(0, 1'b0, 1'b1, 8'h21, 32'hFFFFFFFF, rd);
      check("err_status_wr", 32'(errs[0]), 32'd2);
      access(0, 1'b1, 1'b1, 8'h02, 32'h0BADF00D, rd);
      check("err_dual", 32'(errs[0]), 32'd3);
      access(0, 1'b1, 1'b0, 8'h02, 32'h0, rd);
      check("rd_02_dual", rd, 32'h0BADF00D);
      access(0, 1'b1, 1'b0, 8'h21, 32'h0, rd);
      check("status_idle", rd, 32'h00000300);
      access(0, 1'b1, 1'b0, 8'h20, 32'h0, rd);
      check("rd_ctrl", rd, 32'h0);

      base_s = start_cnt;
      access(0, 1'b0, 1'b1, 8'h20, 32'hFFFFFFFE, rd);
      check("ctrl0_no_start", 32'(start_cnt - base_s), 32'd0);
      check("ctrl0_op_busy", 32'(opb[0]), 32'd0);
      check("ctrl0_err", 32'(errs[0]), 32'd3);

      // Operation A: started, observed busy, then polled until it ends.
      base_s = start_cnt;
      base_b = busy_cyc;
      access(0, 1'b0, 1'b1, 8'h20, 32'h1, rd);
      access(0, 1'b1, 1'b0, 8'h21, 32'h0, rd);
      check("status_busy", rd, 32'h00000301);
      done = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         access(0, 1'b1, 1'b0, 8'h21, 32'h0, rd);
         if (rd[0] == 1'b0) done = 1'b1;
      end
      check("status_poll_end", rd, 32'h00000300);
      repeat (4) @(posedge clk);
      #1;
      check("opA_starts", 32'(start_cnt - base_s), 32'd1);
      check("opA_busy_cycles", 32'(busy_cyc - base_b), 32'd8);

      // Operation B: a second start request while running is rejected.
      base_s = start_cnt;
      base_b = busy_cyc;
      access(0, 1'b0, 1'b1, 8'h20, 32'h1, rd);
      access(0, 1'b0, 1'b1, 8'h20, 32'h1, rd);
      check("ctrl_busy_err", 32'(errs[0]), 32'd4);
      repeat (12) @(posedge clk);
      #1;
      check("opB_starts", 32'(start_cnt - base_s), 32'd1);
      check("opB_busy_cycles", 32'(busy_cyc - base_b), 32'd8);
      access(0, 1'b1, 1'b0, 8'h21, 32'h0, rd);
      check("status_after_opB", rd, 32'h00000400);

      access(1, 1'b0, 1'b1, 8'h1F, 32'h12345678, rd);
      access(1, 1'b1, 1'b0, 8'h1F, 32'h0, rd);
      check("w0_rd_1f", rd, 32'h12345678);

      // Held read request: every ACK is followed by a fresh access.
      addr_s[1] = 8'h80;
      rd_s[1]   = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("w0_held_req_err", 32'(errs[1]), 32'd5);
      repeat (600) @(posedge clk);
      #1;
      check("w0_err_saturate", 32'(errs[1]), 32'hFF);
      rd_s[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset during the wait states of a write while an operation runs.
      access(0, 1'b0, 1'b1, 8'h20, 32'h1, rd);
      addr_s[0] = 8'h03;
      wd_s[0]   = 32'hA5A5A5A5;
      wr_s[0]   = 1'b1;
      @(posedge clk);
      #1;
      check("mid_wait_busy", 32'(busy_s[0]), 32'd1);
      reset_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy_s[0]), 32'd1);
      check("arst_op_busy", 32'(opb[0]), 32'd0);
      check("arst_err", 32'(errs[0]), 32'd0);
      check("arst_rdata", rdata_s[0], 32'h0);
      check("arst_err_u1", 32'(errs[1]), 32'd0);
      wr_s[0] = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy_s[0]), 32'd1);
      access(0, 1'b1, 1'b0, 8'h03, 32'h0, rd);
      check("rd_03_abandoned", rd, 32'h0);
      access(0, 1'b1, 1'b0, 8'h05, 32'h0, rd);
      check("rd_05_cleared", rd, 32'h0);
      check("post_rst_op_busy", 32'(opb[0]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
